// File: rtl/bus_mem_responder_pkg.sv
// Shared definitions for bus_mem_responder: bus width macros, status offsets and the
// address decode helper used by both bus ports.
`ifndef BUS_MEM_RESPONDER_DEFINES
`define BUS_MEM_RESPONDER_DEFINES
`define INST_NOP    32'h0000_0013
`define STAT_ACC    4'h0
`define STAT_FCNT   4'h4
`define STAT_FADDR  4'h8
`define MemAddrBus  31:0
`define MemBus      31:0
`endif

package bus_mem_responder_pkg;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_STAT,
        REGION_MISS
    } region_e;

    localparam int unsigned STAT_BYTES = 16;

    // Word offsets inside the status window, taken from the byte offsets above.
    localparam logic [1:0] STAT_ACC_W   = 2'(`STAT_ACC >> 2);
    localparam logic [1:0] STAT_FCNT_W  = 2'(`STAT_FCNT >> 2);
    localparam logic [1:0] STAT_FADDR_W = 2'(`STAT_FADDR >> 2);

    // Offsets are unsigned differences, so an address below a region wraps to a
    // large value and falls out of range without a separate lower-bound compare.
    function automatic region_e decode_region(input logic [`MemAddrBus] addr,
                                              input logic [`MemAddrBus] base,
                                              input logic [`MemAddrBus] ram_bytes);
        logic [`MemAddrBus] ram_off;
        logic [`MemAddrBus] stat_off;
        ram_off  = addr - base;
        stat_off = addr - (base + ram_bytes);
        if (ram_off < ram_bytes) begin
            return REGION_RAM;
        end
        if (stat_off < 32'(STAT_BYTES)) begin
            return REGION_STAT;
        end
        return REGION_MISS;
    endfunction

endpackage

// File: rtl/bus_mem_responder_if.sv
// Bus bundle between the core (master) and bus_mem_responder (slave): fetch port,
// data port and the fault reporting outputs.
interface bus_mem_responder_if;

    logic [`MemAddrBus] pc_addr_i;
    logic [`MemBus]     pc_data_o;
    logic [`MemAddrBus] ex_addr_i;
    logic [`MemBus]     ex_data_i;
    logic [`MemBus]     ex_data_o;
    logic               ex_req_i;
    logic               ex_we_i;
    logic               err_o;
    logic [31:0]        fault_cnt_o;

    modport master (
        output pc_addr_i, ex_addr_i, ex_data_i, ex_req_i, ex_we_i,
        input  pc_data_o, ex_data_o, err_o, fault_cnt_o
    );

    modport slave (
        input  pc_addr_i, ex_addr_i, ex_data_i, ex_req_i, ex_we_i,
        output pc_data_o, ex_data_o, err_o, fault_cnt_o
    );

endinterface

// File: rtl/bus_mem_responder_ram.sv
// resp_ram: DEPTH x 32 word array with a combinational read port per bus port and a
// single synchronous write port; contents are never reset.
module resp_ram
    import bus_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 4096
) (
    input  logic                       clk,
    input  logic [$clog2(DEPTH)-1:0]   pc_idx,
    output logic [`MemBus]             pc_rdata,
    input  logic [$clog2(DEPTH)-1:0]   ex_idx,
    output logic [`MemBus]             ex_rdata,
    input  logic                       we,
    input  logic [`MemBus]             wdata
);

    logic [`MemBus] mem [DEPTH];

    // Writes land at the edge, so same-cycle reads still see the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[ex_idx] <= wdata;
        end
    end

    assign pc_rdata = mem[pc_idx];
    assign ex_rdata = mem[ex_idx];

endmodule

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: RAM plus status window (ACC_CNT, FAULT_CNT, FAULT_ADDR) serving the
// fetch and data ports. Fault logging is built only when RESP_FAULT_LOG_EN is defined.
module bus_mem_responder
    import bus_mem_responder_pkg::*;
#(
    parameter int unsigned        DEPTH     = 4096,
    parameter logic [`MemAddrBus] BASE_ADDR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_mem_responder_if.slave   bus
);

    localparam int unsigned        AW        = $clog2(DEPTH);
    localparam logic [`MemAddrBus] RAM_BYTES = 32'(4 * DEPTH);

    region_e        pc_region;
    region_e        ex_region;
    logic [AW-1:0]  pc_idx;
    logic [AW-1:0]  ex_idx;
    logic [`MemBus] pc_ram_data;
    logic [`MemBus] ex_ram_data;
    logic           ram_we;
    logic           stat_clear;
    logic [31:0]    acc_cnt;
    logic [`MemBus] stat_rdata;

    assign pc_region = decode_region(bus.pc_addr_i, BASE_ADDR, RAM_BYTES);
    assign ex_region = decode_region(bus.ex_addr_i, BASE_ADDR, RAM_BYTES);

    // BASE_ADDR is aligned to the RAM size, so the word index is a plain slice.
    assign pc_idx = bus.pc_addr_i[AW+1:2];
    assign ex_idx = bus.ex_addr_i[AW+1:2];

    assign ram_we     = rst & bus.ex_req_i & bus.ex_we_i & (ex_region == REGION_RAM);
    assign stat_clear = bus.ex_req_i & bus.ex_we_i & (ex_region == REGION_STAT)
                        & (bus.ex_addr_i[3:2] == STAT_ACC_W);

    resp_ram #(.DEPTH(DEPTH)) u_ram (
        .clk      (clk),
        .pc_idx   (pc_idx),
        .pc_rdata (pc_ram_data),
        .ex_idx   (ex_idx),
        .ex_rdata (ex_ram_data),
        .we       (ram_we),
        .wdata    (bus.ex_data_i)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_cnt <= '0;
        end else if (stat_clear) begin
            acc_cnt <= '0;
        end else if (bus.ex_req_i) begin
            acc_cnt <= acc_cnt + 32'd1;
        end
    end

`ifdef RESP_FAULT_LOG_EN
    logic        pc_fault;
    logic        ex_fault;
    logic [1:0]  fault_inc;
    logic [32:0] fault_sum;
    logic [31:0] fault_cnt;
    logic [31:0] fault_addr;
    logic        err;

    assign pc_fault  = (pc_region != REGION_RAM);
    assign ex_fault  = bus.ex_req_i & (ex_region == REGION_MISS);
    assign fault_inc = {1'b0, pc_fault} + {1'b0, ex_fault};
    assign fault_sum = {1'b0, fault_cnt} + {31'b0, fault_inc};

    // Clear beats any same-cycle fault; the data address wins a double fault.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_cnt  <= '0;
            fault_addr <= '0;
            err        <= 1'b0;
        end else begin
            err <= pc_fault | ex_fault;
            if (stat_clear) begin
                fault_cnt  <= '0;
                fault_addr <= '0;
            end else begin
                fault_cnt <= fault_sum[32] ? 32'hFFFF_FFFF : fault_sum[31:0];
                if (ex_fault) begin
                    fault_addr <= bus.ex_addr_i;
                end else if (pc_fault) begin
                    fault_addr <= bus.pc_addr_i;
                end
            end
        end
    end

    assign bus.err_o       = err;
    assign bus.fault_cnt_o = fault_cnt;
`else
    assign bus.err_o       = 1'b0;
    assign bus.fault_cnt_o = '0;
`endif

    // ACC_CNT reads back including the reading access itself.
    always_comb begin
        stat_rdata = '0;
        case (bus.ex_addr_i[3:2])
            STAT_ACC_W:   stat_rdata = acc_cnt + 32'd1;
`ifdef RESP_FAULT_LOG_EN
            STAT_FCNT_W:  stat_rdata = fault_cnt;
            STAT_FADDR_W: stat_rdata = fault_addr;
`endif
            default:      stat_rdata = '0;
        endcase
    end

    always_comb begin
        bus.ex_data_o = '0;
        if (bus.ex_req_i) begin
            case (ex_region)
                REGION_RAM:  bus.ex_data_o = ex_ram_data;
                REGION_STAT: bus.ex_data_o = stat_rdata;
                default:     bus.ex_data_o = '0;
            endcase
        end
    end

    assign bus.pc_data_o = (pc_region == REGION_RAM) ? pc_ram_data : `INST_NOP;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder: directed scenarios plus randomized traffic
// against a behavioural memory/counter model.
module tb_bus_mem_responder;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] STAT  = BASE + 32'(4 * DEPTH);
`ifdef RESP_FAULT_LOG_EN
    localparam bit FLOG = 1'b1;
`else
    localparam bit FLOG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    bus_mem_responder_if bus ();

    bus_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_acc;
    logic [31:0] m_fcnt;
    logic [31:0] m_faddr;
    logic        m_err;

    function automatic bit in_ram(input logic [31:0] a);
        return (a >= BASE) && (a < STAT);
    endfunction

    function automatic bit in_stat(input logic [31:0] a);
        return (a >= STAT) && (a < STAT + 32'd16);
    endfunction

    function automatic logic [31:0] exp_pc(input logic [31:0] a);
        return in_ram(a) ? m_mem[int'((a - BASE) >> 2)] : 32'h0000_0013;
    endfunction

    function automatic logic [31:0] exp_ex(input logic [31:0] a, input bit req);
        if (!req) return 32'h0;
        if (in_ram(a)) return m_mem[int'((a - BASE) >> 2)];
        if (in_stat(a)) begin
            case (int'((a - STAT) >> 2))
                0:       return m_acc + 32'd1;
                1:       return FLOG ? m_fcnt : 32'h0;
                2:       return FLOG ? m_faddr : 32'h0;
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    function automatic void model_step(input logic [31:0] pc, input logic [31:0] a,
                                       input logic [31:0] d, input bit req, input bit we);
        bit     pfault;
        bit     dfault;
        bit     clr;
        int     nf;
        longint s;
        pfault = FLOG && !in_ram(pc);
        dfault = FLOG && req && !in_ram(a) && !in_stat(a);
        nf     = int'(pfault) + int'(dfault);
        clr    = req && we && in_stat(a) && ((a - STAT) < 32'd4);
        if (req && we && in_ram(a)) m_mem[int'((a - BASE) >> 2)] = d;
        m_err = (nf > 0);
        if (clr) begin
            m_acc = 0; m_fcnt = 0; m_faddr = 0;
        end else begin
            if (req) m_acc = m_acc + 32'd1;
            s = longint'(m_fcnt) + longint'(nf);
            m_fcnt = (s > 64'sh0_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
            if (dfault) m_faddr = a;
            else if (pfault) m_faddr = pc;
        end
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d,
                         input bit req, input bit we);
        bus.pc_addr_i = pc;
        bus.ex_addr_i = a;
        bus.ex_data_i = d;
        bus.ex_req_i  = req;
        bus.ex_we_i   = we;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step(bus.pc_addr_i, bus.ex_addr_i, bus.ex_data_i, bus.ex_req_i, bus.ex_we_i);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m_acc = 0; m_fcnt = 0; m_faddr = 0; m_err = 0;
        drive(BASE, 32'h0, 32'h0, 1'b0, 1'b0);
        tick(); tick();
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err_o); end
        total++; if (bus.fault_cnt_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_fcnt: got %h expected 0", bus.fault_cnt_o); end
        total++; if (bus.ex_data_o !== 32'h0) begin bad++; $display("[TB] FAIL idle_rdata: got %h expected 0", bus.ex_data_o); end
        rst = 1'b1;
        drive(BASE, STAT, 32'h0, 1'b1, 1'b0);
        total++; if (bus.ex_data_o !== 32'd1) begin bad++; $display("[TB] FAIL reset_acc: got %h expected 1", bus.ex_data_o); end
        tick();
        drive(BASE, STAT + 32'h4, 32'h0, 1'b1, 1'b0);
        total++; if (bus.ex_data_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_fcnt_read: got %h expected 0", bus.ex_data_o); end
        tick();
    endtask

    task automatic test_preload();
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(BASE, BASE + 32'(4 * i), $urandom, 1'b1, 1'b1);
            tick();
        end
        drive(BASE, STAT, 32'h0, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_write_read();
        drive(BASE, BASE + 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b1);
        tick();
        drive(BASE + 32'h10, BASE + 32'h10, 32'h0, 1'b1, 1'b0);
        total++; if (bus.ex_data_o !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL wr_rd_data: got %h expected deadbeef", bus.ex_data_o); end
        total++; if (bus.pc_data_o !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL wr_rd_fetch: got %h expected deadbeef", bus.pc_data_o); end
        tick();
    endtask

    task automatic test_same_cycle();
        drive(BASE, BASE + 32'h20, 32'h0000_0013, 1'b1, 1'b1);
        tick();
        drive(BASE + 32'h20, BASE + 32'h20, 32'h1234_5678, 1'b1, 1'b1);
        total++; if (bus.pc_data_o !== 32'h0000_0013) begin bad++; $display("[TB] FAIL same_cycle_old: got %h expected 00000013", bus.pc_data_o); end
        tick();
        drive(BASE + 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);
        total++; if (bus.pc_data_o !== 32'h1234_5678) begin bad++; $display("[TB] FAIL same_cycle_new: got %h expected 12345678", bus.pc_data_o); end
        tick();
    endtask

    task automatic test_double_fault();
        drive(BASE, STAT, 32'h0, 1'b1, 1'b1);
        tick();
        drive(STAT + 32'h40, STAT + 32'h40, 32'h0, 1'b1, 1'b0);
        total++; if (bus.pc_data_o !== 32'h0000_0013) begin bad++; $display("[TB] FAIL dfault_nop: got %h expected 00000013", bus.pc_data_o); end
        total++; if (bus.ex_data_o !== 32'h0) begin bad++; $display("[TB] FAIL dfault_rdata: got %h expected 0", bus.ex_data_o); end
        tick();
        drive(BASE, STAT + 32'h4, 32'h0, 1'b1, 1'b0);
        total++; if (bus.err_o !== FLOG) begin bad++; $display("[TB] FAIL dfault_err: got %b expected %b", bus.err_o, FLOG); end
        total++; if (bus.fault_cnt_o !== (FLOG ? 32'd2 : 32'd0)) begin bad++; $display("[TB] FAIL dfault_cnt: got %h expected %h", bus.fault_cnt_o, FLOG ? 32'd2 : 32'd0); end
        total++; if (bus.ex_data_o !== (FLOG ? 32'd2 : 32'd0)) begin bad++; $display("[TB] FAIL dfault_cnt_read: got %h expected %h", bus.ex_data_o, FLOG ? 32'd2 : 32'd0); end
        tick();
        drive(BASE, STAT + 32'h8, 32'h0, 1'b1, 1'b0);
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("[TB] FAIL dfault_err_drop: got %b expected 0", bus.err_o); end
        total++; if (bus.ex_data_o !== (FLOG ? STAT + 32'h40 : 32'h0)) begin bad++; $display("[TB] FAIL dfault_addr: got %h expected %h", bus.ex_data_o, FLOG ? STAT + 32'h40 : 32'h0); end
        tick();
    endtask

    task automatic test_acc_count();
        drive(BASE, STAT, 32'h0, 1'b1, 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(BASE, BASE + 32'(4 * k), 32'h0, 1'b1, 1'b0);
            tick();
        end
        drive(BASE, STAT, 32'h0, 1'b1, 1'b0);
        total++; if (bus.ex_data_o !== 32'd6) begin bad++; $display("[TB] FAIL acc_six: got %h expected 6", bus.ex_data_o); end
        tick();
        drive(BASE, STAT, 32'h0, 1'b1, 1'b1);
        tick();
        drive(BASE, STAT, 32'h0, 1'b1, 1'b0);
        total++; if (bus.ex_data_o !== 32'd1) begin bad++; $display("[TB] FAIL acc_cleared: got %h expected 1", bus.ex_data_o); end
        tick();
    endtask

    task automatic test_saturation();
`ifdef RESP_FAULT_LOG_EN
        drive(BASE, 32'h0, 32'h0, 1'b0, 1'b0);
        force dut.fault_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.fault_cnt;
        m_fcnt = 32'hFFFF_FFFE;
        drive(STAT + 32'h40, STAT + 32'h40, 32'h0, 1'b1, 1'b0);
        tick();
        total++; if (bus.fault_cnt_o !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL sat_double: got %h expected ffffffff", bus.fault_cnt_o); end
        drive(STAT + 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        total++; if (bus.fault_cnt_o !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL sat_hold: got %h expected ffffffff", bus.fault_cnt_o); end
        drive(BASE, STAT, 32'h0, 1'b1, 1'b1);
        tick();
`endif
    endtask

    task automatic test_reset_mid_write();
        drive(BASE, BASE + 32'h30, 32'h0, 1'b1, 1'b1);
        tick();
        drive(STAT + 32'h40, BASE + 32'h30, 32'hAAAA_5555, 1'b1, 1'b1);
        #2;
        rst = 1'b0;
        m_acc = 0; m_fcnt = 0; m_faddr = 0; m_err = 0;
        tick();
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("[TB] FAIL midrst_err: got %b expected 0", bus.err_o); end
        total++; if (bus.fault_cnt_o !== 32'h0) begin bad++; $display("[TB] FAIL midrst_fcnt: got %h expected 0", bus.fault_cnt_o); end
        drive(BASE, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(BASE, STAT, 32'h0, 1'b1, 1'b0);
        total++; if (bus.ex_data_o !== 32'd1) begin bad++; $display("[TB] FAIL midrst_acc: got %h expected 1", bus.ex_data_o); end
        tick();
        drive(BASE, STAT + 32'h8, 32'h0, 1'b1, 1'b0);
        total++; if (bus.ex_data_o !== 32'h0) begin bad++; $display("[TB] FAIL midrst_faddr: got %h expected 0", bus.ex_data_o); end
        tick();
        drive(BASE + 32'h30, BASE + 32'h30, 32'h0, 1'b1, 1'b0);
        total++; if (bus.ex_data_o !== 32'h0) begin bad++; $display("[TB] FAIL midrst_word: got %h expected 0", bus.ex_data_o); end
        total++; if (bus.pc_data_o !== 32'h0) begin bad++; $display("[TB] FAIL midrst_fetch: got %h expected 0", bus.pc_data_o); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] d;
        bit          req;
        bit          we;
        int          r;
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8)       pc = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            else if (r == 8) pc = STAT + 32'($urandom_range(0, 15));
            else             pc = $urandom;
            r = int'($urandom_range(0, 9));
            if (r < 6)       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            else if (r < 8)  a = STAT + 32'($urandom_range(0, 15));
            else             a = $urandom;
            req = ($urandom_range(0, 3) != 0);
            we  = ($urandom_range(0, 2) == 0);
            d   = $urandom;
            drive(pc, a, d, req, we);
            total++; if (bus.pc_data_o !== exp_pc(pc)) begin bad++; $display("[TB] FAIL rnd_fetch @%h: got %h expected %h", pc, bus.pc_data_o, exp_pc(pc)); end
            if (!(req && we)) begin
                total++; if (bus.ex_data_o !== exp_ex(a, req)) begin bad++; $display("[TB] FAIL rnd_rdata @%h: got %h expected %h", a, bus.ex_data_o, exp_ex(a, req)); end
            end
            tick();
            total++; if (bus.err_o !== m_err) begin bad++; $display("[TB] FAIL rnd_err: got %b expected %b", bus.err_o, m_err); end
            total++; if (bus.fault_cnt_o !== m_fcnt) begin bad++; $display("[TB] FAIL rnd_fcnt: got %h expected %h", bus.fault_cnt_o, m_fcnt); end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_preload();
        test_write_read();
        test_same_cycle();
        test_double_fault();
        test_acc_count();
        test_saturation();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_mem_responder.md
# bus_mem_responder

Memory-side responder for the core's two bus initiator ports: the instruction-fetch port (pc address in, instruction out) and the execute-stage data port (addr/req/we/wdata out, rdata in). It holds a word-organised RAM array serving both ports. It also holds a small memory-mapped status window that counts data accesses and logs out-of-range faults. It sits in the SoC top between the core and the rest of the address space.

## Interface
Parameters:
- DEPTH, 4096: RAM size in 32-bit words; power of two, ≥ 16.
- BASE_ADDR, 32'h0000_0000: byte address of RAM word 0; aligned to 4*DEPTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- pc_addr_i  input  32  fetch byte address.
- pc_data_o  output  32  fetched instruction; combinational.
- ex_addr_i  input  32  data byte address.
- ex_data_i  input  32  write data.
- ex_data_o  output  32  read data; combinational.
- ex_req_i  input  1  data access request, valid for one cycle.
- ex_we_i  input  1  1 = write, 0 = read; qualified by ex_req_i.
- err_o  output  1  registered fault pulse.
- fault_cnt_o  output  32  current fault count.

## Operation
Address decode:
- RAM hit: BASE_ADDR ≤ addr < BASE_ADDR + 4*DEPTH. Word index = (addr − BASE_ADDR) >> 2. addr[1:0] is ignored.
- Status window: STAT_BASE = BASE_ADDR + 4*DEPTH, 16 bytes.
  - offset 0x0: ACC_CNT.
  - offset 0x4: FAULT_CNT.
  - offset 0x8: FAULT_ADDR.
  - offset 0xC: reads 0.
- Fetch port:
  - RAM hit: returns the RAM word.
  - Miss: returns `INST_NOP (32'h0000_0013) and is a fetch fault.
- Data read (req=1, we=0):
  - RAM hit: returns the RAM word.
  - Status window: returns the register value.
  - Otherwise: returns 0 and is a data fault.
  - req=0: ex_data_o = 0.
- Data write (req=1, we=1):
  - RAM hit: the word is written at the clock edge.
  - Any write to status offset 0x0: clears ACC_CNT, FAULT_CNT and FAULT_ADDR.
  - Writes to other status offsets: ignored, not a fault.
  - Write outside both regions: dropped, counts as a data fault.
- ACC_CNT: +1 on every cycle with ex_req_i=1. Wraps 0xFFFF_FFFF → 0.
- FAULT_CNT: increases by the number of faults in the cycle (0, 1 or 2). Saturates at 0xFFFF_FFFF.
- FAULT_ADDR: updated with the faulting address. If both ports fault in the same cycle, the data address wins.

## Timing
- Reads on both ports are zero-latency (combinational from address); this matches the core's single-cycle bus.
- A write is visible to either port from the cycle after the write edge. A same-cycle fetch or read of the written word returns the old value.
- err_o is 1 for exactly the cycle after any fault cycle. Back-to-back faults hold it high.
- Clear has priority over same-cycle count and log updates: after a clear edge, all three registers are 0, including any fault in that cycle.
- Reset values:
  - ACC_CNT, FAULT_CNT, FAULT_ADDR = 0.
  - err_o = 0.
  - fault_cnt_o = 0.
- The RAM is not cleared by reset.
- RAM writes are suppressed while rst is low. A request coinciding with reset assertion is dropped entirely.
- ex_we_i with ex_req_i=0 has no effect.

## Configuration
- RESP_FAULT_LOG_EN defined:
  - Fault detection, FAULT_CNT, FAULT_ADDR and err_o are implemented as above.
- Not defined:
  - No fault logic is built.
  - err_o and fault_cnt_o are tied 0.
  - Status offsets 0x4 and 0x8 read 0.
  - Out-of-range accesses still return `INST_NOP (fetch) or 0 (data) and are silently dropped.
  - ACC_CNT and its clear are always present.

## Structure
- Shared definitions belong in defines.v:
  - `INST_NOP.
  - status offsets `STAT_ACC, `STAT_FCNT, `STAT_FADDR.
  - the existing `MemAddrBus/`MemBus widths.
- One sub-module: resp_ram, the DEPTH×32 array with one combinational read port per bus port and one synchronous write port.
- Decode, counters and fault logging live in bus_mem_responder.

## Test plan
- Write 32'hDEAD_BEEF to BASE+0x10, read it back the next cycle → ex_data_o = 32'hDEAD_BEEF; a fetch from BASE+0x10 returns the same value.
- Same-cycle write 32'h1234_5678 to BASE+0x20 with fetch from BASE+0x20 (old value 0x0000_0013) → pc_data_o = 0x0000_0013 that cycle and 0x1234_5678 the next.
- Fetch from STAT_BASE+0x40 with a data read from STAT_BASE+0x40 in the same cycle → pc_data_o = 0x0000_0013, ex_data_o = 0, FAULT_CNT = 2, FAULT_ADDR = the data address, err_o high one cycle.
- 5 data requests, then read ACC_CNT → 6 (the read itself counts); write to STAT_BASE+0x0, then read ACC_CNT → 1.
- Preload FAULT_CNT to 0xFFFF_FFFE via forced faults, then force a double fault → FAULT_CNT = 0xFFFF_FFFF; one more fault → stays 0xFFFF_FFFF.
- Assert rst mid-write to BASE+0x30 (old value 0) → the word remains 0, all counters read 0, err_o = 0; rebuild without RESP_FAULT_LOG_EN → the fault scenario gives err_o = 0, fault_cnt_o = 0.
